gumnut_pc_unit: RTL and testbench
=================================

Name: gumnut_pc_unit

Overview:
- Program-counter and return-address unit directly downstream of the control unit.
- Consumes PCEn_o, PCoper_o, jsb_o, ret_o, int_o and reti_o from the control unit, plus Z/C flags from the ALU.
- Keeps the 12-bit PC, an on-chip return-address stack, and the interrupt save registers for PC, Z, C and IE.
- Drives the instruction-bus address and the interrupt-enable state seen by the interrupt logic.

Parameters:
- PC_W, 12, program counter / instruction address width.
- STK_DEPTH, 8, return stack entries; must be a power of 2, minimum 2.
- INT_VEC, 12'h001, PC loaded on interrupt entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_en_i  in  1  update strobe from the control unit; when low, all state holds.
- pc_oper_i  in  4  operation select, valid while pc_en_i is high.
- jsb_i  in  1  subroutine call strobe.
- ret_i  in  1  subroutine return strobe.
- int_i  in  1  interrupt entry strobe.
- reti_i  in  1  interrupt return strobe.
- ie_set_i  in  1  set interrupt enable (misc instruction).
- ie_clr_i  in  1  clear interrupt enable (misc instruction).
- z_i  in  1  ALU zero flag.
- c_i  in  1  ALU carry flag.
- disp_i  in  8  signed branch displacement from the instruction register.
- addr_i  in  PC_W  absolute jump/call target from the instruction register.
- inst_adr_o  out  PC_W  current PC, driven to the instruction bus.
- ie_o  out  1  interrupt enable; the interrupt request is gated with this.
- flag_restore_o  out  1  one-cycle strobe: ALU must reload Z/C from int_z_o/int_c_o.
- int_z_o  out  1  saved Z flag.
- int_c_o  out  1  saved C flag.

Behaviour:
- Reset: PC=0, inst_adr_o=0, ie_o=0, flag_restore_o=0, int_z_o=0, int_c_o=0, stack pointer=0, stack entries=0.
- All updates take effect one clock after the qualifying input edge; inst_adr_o is the PC register, with no combinational path from inputs.
- Nothing changes when pc_en_i=0, except ie_set_i/ie_clr_i, which act on any cycle.
- Priority when pc_en_i=1: int_i > reti_i > jsb_i > ret_i > pc_oper_i.
- int_i:
  - int_pc <= PC, int_z_o <= z_i, int_c_o <= c_i, int_ie <= ie_o.
  - PC <= INT_VEC, ie_o <= 0.
- reti_i: PC <= int_pc, ie_o <= int_ie, flag_restore_o=1 for exactly one cycle.
- jsb_i: push PC+1, then PC <= addr_i.
- ret_i: pop; PC <= top entry.
- pc_oper_i encoding:
  - 0000: PC+1.
  - 0100: branch if Z=1.
  - 0101: branch if Z=0.
  - 0110: branch if C=1.
  - 0111: branch if C=0.
  - 1000: PC <= addr_i.
  - All other codes: PC+1.
- Branch taken: PC <= PC + sign-extended disp_i. Not taken: PC+1.
- Arithmetic is modulo 2^PC_W; 12'hFFF+1 wraps to 0 and is not an error.
- Stack is circular:
  - Push on full overwrites the oldest entry; the pointer wraps.
  - Pop on empty returns whatever entry the pointer wraps to.
- ie_set_i and ie_clr_i together: clear wins.
- ie_set_i/ie_clr_i in the same cycle as int_i/reti_i: int_i/reti_i win.
- Reset mid-operation (during a push or reti) discards the operation; all state takes its reset values.

Optional Feature:
- Macro: GUMNUT_PC_STK_CHECK_EN.
- With it: adds output stk_err_o (1 bit), a sticky flag.
  - Set on push when full, or pop when empty.
  - Cleared only by rst.
  - The wrap behaviour is unchanged.
- Without it: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package gumnut_pkg:
  - pc_oper_t enum for the 4-bit codes above, so the control unit uses the same constants.
  - PC_W default and INT_VEC constant.
- Sub-module gumnut_ret_stack:
  - Inputs: push/pop/data.
  - Outputs: top, full, empty.
  - Holds the circular buffer and its pointer; gumnut_pc_unit instantiates it once.

Test Plan:
1. rst=1 while PC=12'h3A0 and ie_o=1 -> next cycle PC=0, ie_o=0, flag_restore_o=0.
2. PC=12'h010, pc_oper 0100, z_i=1, disp_i=8'hFC -> PC=12'h00C. Same with z_i=0 -> PC=12'h011.
3. PC=12'h020, jsb_i with addr_i=12'h100 -> PC=12'h100. Then ret_i -> PC=12'h021.
4. Nine nested jsb_i then nine ret_i (STK_DEPTH=8):
   - Eighth pop returns the second-pushed address.
   - With GUMNUT_PC_STK_CHECK_EN, stk_err_o=1 after the ninth push.
5. PC=12'h055, ie_o=1, z_i=1, c_i=0, int_i -> PC=12'h001, ie_o=0, int_z_o=1, int_c_o=0. Then reti_i -> PC=12'h055, ie_o=1, flag_restore_o pulses for one cycle.
6. int_i and jsb_i in the same cycle -> int taken, stack unchanged. pc_en_i=0 with pc_oper 1000 -> PC holds.

Source files
------------

// File: rtl/gumnut_pkg.sv
// gumnut_pkg: PC operation codes and PC unit constants shared with the control unit.
package gumnut_pkg;
   localparam int GUMNUT_PC_W = 12;
   localparam int GUMNUT_STK_DEPTH = 8;
   localparam logic [GUMNUT_PC_W-1:0] GUMNUT_INT_VEC = 12'h001;
   typedef enum logic [3:0] {
      OP_INC = 4'b0000,
      OP_BZ  = 4'b0100,
      OP_BNZ = 4'b0101,
      OP_BC  = 4'b0110,
      OP_BNC = 4'b0111,
      OP_JMP = 4'b1000
   } pc_oper_t;
endpackage

// File: rtl/gumnut_ret_stack.sv
// gumnut_ret_stack: circular return-address stack; pushes on full overwrite the oldest entry.
module gumnut_ret_stack #(
   parameter int W = 12,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] data,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] sp;
   logic [AW:0] cnt;
   assign top = mem[sp - 1'b1];
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   // The pointer always moves; the count saturates so full/empty stay meaningful after wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[sp] <= data;
         sp <= sp + 1'b1;
         cnt <= full ? cnt : cnt + 1'b1;
      end else if (pop) begin
         sp <= sp - 1'b1;
         cnt <= empty ? cnt : cnt - 1'b1;
      end
   end
endmodule

// File: rtl/gumnut_pc_unit.sv
// gumnut_pc_unit: PC, return stack and interrupt save state.
// Optional GUMNUT_PC_STK_CHECK_EN adds sticky stk_err_o for stack overflow/underflow.
module gumnut_pc_unit
   import gumnut_pkg::*;
#(
   parameter int PC_W = GUMNUT_PC_W,
   parameter int STK_DEPTH = GUMNUT_STK_DEPTH,
   parameter logic [PC_W-1:0] INT_VEC = GUMNUT_INT_VEC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_en_i,
   input  logic [3:0]      pc_oper_i,
   input  logic            jsb_i,
   input  logic            ret_i,
   input  logic            int_i,
   input  logic            reti_i,
   input  logic            ie_set_i,
   input  logic            ie_clr_i,
   input  logic            z_i,
   input  logic            c_i,
   input  logic [7:0]      disp_i,
   input  logic [PC_W-1:0] addr_i,
`ifdef GUMNUT_PC_STK_CHECK_EN
   output logic            stk_err_o,
`endif
   output logic [PC_W-1:0] inst_adr_o,
   output logic            ie_o,
   output logic            flag_restore_o,
   output logic            int_z_o,
   output logic            int_c_o
);
   pc_oper_t op;
   logic [PC_W-1:0] pc, pc_nxt, pc_inc, pc_br, int_pc, stk_top;
   logic int_ie, taken, push, pop, full, empty;
   assign op = pc_oper_t'(pc_oper_i);
   assign inst_adr_o = pc;
   assign pc_inc = pc + 1'b1;
   assign pc_br = pc + {{(PC_W-8){disp_i[7]}}, disp_i};
   assign push = pc_en_i && !int_i && !reti_i && jsb_i;
   assign pop = pc_en_i && !int_i && !reti_i && !jsb_i && ret_i;
   always_comb begin
      taken = (op == OP_BZ && z_i) || (op == OP_BNZ && !z_i) ||
              (op == OP_BC && c_i) || (op == OP_BNC && !c_i);
      pc_nxt = int_i ? INT_VEC : reti_i ? int_pc : jsb_i ? addr_i : ret_i ? stk_top :
               op == OP_JMP ? addr_i : taken ? pc_br : pc_inc;
   end
   gumnut_ret_stack #(.W(PC_W), .DEPTH(STK_DEPTH)) u_stack (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .data(pc_inc),
      .top(stk_top), .full(full), .empty(empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
         int_pc <= '0;
         int_z_o <= 1'b0;
         int_c_o <= 1'b0;
         int_ie <= 1'b0;
         ie_o <= 1'b0;
         flag_restore_o <= 1'b0;
      end else begin
         flag_restore_o <= pc_en_i && !int_i && reti_i;
         if (pc_en_i) pc <= pc_nxt;
         if (pc_en_i && int_i) begin
            int_pc <= pc;
            int_z_o <= z_i;
            int_c_o <= c_i;
            int_ie <= ie_o;
         end
         // Interrupt entry/return own ie_o over the misc set/clear strobes.
         ie_o <= (pc_en_i && int_i) ? 1'b0 : (pc_en_i && reti_i) ? int_ie :
                 ie_clr_i ? 1'b0 : ie_set_i ? 1'b1 : ie_o;
      end
   end
`ifdef GUMNUT_PC_STK_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) stk_err_o <= 1'b0;
      else if ((push && full) || (pop && empty)) stk_err_o <= 1'b1;
   end
`else
   logic unused_stk;
   assign unused_stk = full ^ empty;
`endif
endmodule

// File: tb/tb_gumnut_pc_unit.sv
// tb_gumnut_pc_unit: directed checks of the PC unit with hand-computed expectations.
module tb_gumnut_pc_unit;
   logic clk = 1'b0, rst, pc_en_i, jsb_i, ret_i, int_i, reti_i, ie_set_i, ie_clr_i, z_i, c_i;
   logic [3:0] pc_oper_i;
   logic [7:0] disp_i;
   logic [11:0] addr_i, inst_adr_o;
   logic ie_o, flag_restore_o, int_z_o, int_c_o;
`ifdef GUMNUT_PC_STK_CHECK_EN
   logic stk_err_o;
`endif
   int checks = 0, failures = 0;

   gumnut_pc_unit dut (
      .clk(clk), .rst(rst), .pc_en_i(pc_en_i), .pc_oper_i(pc_oper_i), .jsb_i(jsb_i),
      .ret_i(ret_i), .int_i(int_i), .reti_i(reti_i), .ie_set_i(ie_set_i), .ie_clr_i(ie_clr_i),
      .z_i(z_i), .c_i(c_i), .disp_i(disp_i), .addr_i(addr_i),
`ifdef GUMNUT_PC_STK_CHECK_EN
      .stk_err_o(stk_err_o),
`endif
      .inst_adr_o(inst_adr_o), .ie_o(ie_o), .flag_restore_o(flag_restore_o),
      .int_z_o(int_z_o), .int_c_o(int_c_o)
   );

   always #5 clk = ~clk;

   task automatic idle();
      {rst, pc_en_i, jsb_i, ret_i, int_i, reti_i, ie_set_i, ie_clr_i, z_i, c_i} = '0;
      pc_oper_i = 4'b0000;
      disp_i = 8'h00;
      addr_i = 12'h000;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic jmp(input logic [11:0] a);
      pc_en_i = 1'b1;
      pc_oper_i = 4'b1000;
      addr_i = a;
      cyc();
   endtask

   task automatic test_reset();
      jmp(12'h3A0);
      ie_set_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h3A0 || ie_o !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset pc=%h ie=%b want 3a0 1", inst_adr_o, ie_o);
      end
      rst = 1'b1;
      pc_en_i = 1'b1;
      reti_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h000 || ie_o !== 1'b0 || flag_restore_o !== 1'b0 ||
          int_z_o !== 1'b0 || int_c_o !== 1'b0) begin
         failures++;
         $display("FAIL reset pc=%h ie=%b fr=%b z=%b c=%b want 000 0 0 0 0",
                  inst_adr_o, ie_o, flag_restore_o, int_z_o, int_c_o);
      end
   endtask

   task automatic test_branch();
      jmp(12'h010);
      pc_en_i = 1'b1; pc_oper_i = 4'b0100; z_i = 1'b1; disp_i = 8'hFC;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h00C) begin
         failures++;
         $display("FAIL bz_taken got %h want 00c", inst_adr_o);
      end
      jmp(12'h010);
      pc_en_i = 1'b1; pc_oper_i = 4'b0100; z_i = 1'b0; disp_i = 8'hFC;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h011) begin
         failures++;
         $display("FAIL bz_not_taken got %h want 011", inst_adr_o);
      end
      pc_en_i = 1'b1; pc_oper_i = 4'b0110; c_i = 1'b1; disp_i = 8'h05;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h016) begin
         failures++;
         $display("FAIL bc_taken got %h want 016", inst_adr_o);
      end
      pc_en_i = 1'b1; pc_oper_i = 4'b0111; c_i = 1'b1; disp_i = 8'h05;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h017) begin
         failures++;
         $display("FAIL bnc_not_taken got %h want 017", inst_adr_o);
      end
      pc_en_i = 1'b1; pc_oper_i = 4'b0101; z_i = 1'b0; disp_i = 8'h10;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h027) begin
         failures++;
         $display("FAIL bnz_taken got %h want 027", inst_adr_o);
      end
      jmp(12'hFFF);
      pc_en_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h000) begin
         failures++;
         $display("FAIL inc_wrap got %h want 000", inst_adr_o);
      end
      pc_en_i = 1'b1; pc_oper_i = 4'b1111; addr_i = 12'h555; z_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h001) begin
         failures++;
         $display("FAIL undef_op got %h want 001", inst_adr_o);
      end
   endtask

   task automatic test_call();
      jmp(12'h020);
      pc_en_i = 1'b1; jsb_i = 1'b1; addr_i = 12'h100;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h100) begin
         failures++;
         $display("FAIL jsb got %h want 100", inst_adr_o);
      end
      pc_en_i = 1'b1; ret_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h021) begin
         failures++;
         $display("FAIL ret got %h want 021", inst_adr_o);
      end
   endtask

   task automatic test_nested();
      logic [11:0] pushed [9];
      logic [11:0] pc_e, want;
      rst = 1'b1;
      cyc();
      pc_e = 12'h000;
      for (int k = 0; k < 9; k++) begin
         pushed[k] = pc_e + 12'h001;
         pc_e = 12'h100 + 12'(16 * k);
         pc_en_i = 1'b1; jsb_i = 1'b1; addr_i = pc_e;
         cyc();
         checks++;
         if (inst_adr_o !== pc_e) begin
            failures++;
            $display("FAIL nest_push%0d got %h want %h", k, inst_adr_o, pc_e);
         end
`ifdef GUMNUT_PC_STK_CHECK_EN
         checks++;
         if (stk_err_o !== (k == 8)) begin
            failures++;
            $display("FAIL stk_err_push%0d got %b want %b", k, stk_err_o, k == 8);
         end
`endif
      end
      // The ninth push overwrote the first; the ninth pop wraps onto that slot.
      for (int j = 0; j < 9; j++) begin
         want = (j == 8) ? pushed[8] : pushed[8 - j];
         pc_en_i = 1'b1; ret_i = 1'b1;
         cyc();
         checks++;
         if (inst_adr_o !== want) begin
            failures++;
            $display("FAIL nest_pop%0d got %h want %h", j, inst_adr_o, want);
         end
      end
   endtask

   task automatic test_int();
      jmp(12'h055);
      ie_set_i = 1'b1;
      cyc();
      pc_en_i = 1'b1; int_i = 1'b1; z_i = 1'b1; c_i = 1'b0; ie_set_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h001 || ie_o !== 1'b0 || int_z_o !== 1'b1 ||
          int_c_o !== 1'b0 || flag_restore_o !== 1'b0) begin
         failures++;
         $display("FAIL int_entry pc=%h ie=%b z=%b c=%b fr=%b want 001 0 1 0 0",
                  inst_adr_o, ie_o, int_z_o, int_c_o, flag_restore_o);
      end
      pc_en_i = 1'b1;
      cyc();
      pc_en_i = 1'b1; reti_i = 1'b1; ie_clr_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h055 || ie_o !== 1'b1 || flag_restore_o !== 1'b1) begin
         failures++;
         $display("FAIL reti pc=%h ie=%b fr=%b want 055 1 1", inst_adr_o, ie_o, flag_restore_o);
      end
      pc_en_i = 1'b1;
      cyc();
      checks++;
      if (flag_restore_o !== 1'b0 || inst_adr_o !== 12'h056 || int_z_o !== 1'b1) begin
         failures++;
         $display("FAIL fr_pulse fr=%b pc=%h z=%b want 0 056 1", flag_restore_o, inst_adr_o, int_z_o);
      end
   endtask

   task automatic test_priority();
      jmp(12'h300);
      pc_en_i = 1'b1; jsb_i = 1'b1; addr_i = 12'h400;
      cyc();
      pc_en_i = 1'b1; jsb_i = 1'b1; int_i = 1'b1; addr_i = 12'h500;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h001) begin
         failures++;
         $display("FAIL int_over_jsb got %h want 001", inst_adr_o);
      end
      pc_en_i = 1'b1; ret_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h301) begin
         failures++;
         $display("FAIL stack_untouched got %h want 301", inst_adr_o);
      end
      pc_oper_i = 4'b1000; addr_i = 12'h777; jsb_i = 1'b1; ie_set_i = 1'b1;
      cyc();
      checks++;
      if (inst_adr_o !== 12'h301 || ie_o !== 1'b1) begin
         failures++;
         $display("FAIL pc_hold pc=%h ie=%b want 301 1", inst_adr_o, ie_o);
      end
      ie_set_i = 1'b1; ie_clr_i = 1'b1;
      cyc();
      checks++;
      if (ie_o !== 1'b0) begin
         failures++;
         $display("FAIL ie_clr_wins got %b want 0", ie_o);
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();
      test_reset();
      test_branch();
      test_call();
      test_nested();
      test_int();
      test_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
